// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues PC to synchronous instruction memory and buffers
// {instr, pc, fault} in a small FIFO toward decode, with credit-based back-pressure.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          IM_ADDR_W = 12,
    parameter logic [31:0] PC_BASE   = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc,
    input  logic                 pc_valid,
    output logic                 pc_ready,
    input  logic                 flush,
    output logic [IM_ADDR_W-1:0] im_addr,
    input  logic [31:0]          im_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_pc,
    output logic                 out_exc
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_BASE} + (33'd1 << (IM_ADDR_W + 2));

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    entry_t [DEPTH-1:0] q;
    entry_t             head;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [PW:0]        count;
    logic [PW+1:0]      occ;
    logic               inflight;
    logic [31:0]        ret_pc;
    logic               ret_exc;
    logic               fault, accept, push, pop;

    assign im_addr = IM_ADDR_W'((pc - PC_BASE) >> 2);
    assign fault   = (pc[1:0] != 2'b00) || (pc < PC_BASE) || ({1'b0, pc} >= PC_LIMIT);

    // The in-flight fetch already owns a slot, so the queue can never overflow.
    assign occ      = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
    assign pc_ready = !rst && !flush && (occ < (PW+2)'(DEPTH));
    assign accept   = pc_valid && pc_ready;
    assign push     = inflight && !flush;
    assign pop      = out_valid && out_ready && !flush;

    assign out_valid = (count != '0);
    assign head      = q[rd_ptr];
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_exc   = out_valid ? head.exc   : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
            ret_pc   <= '0;
            ret_exc  <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                inflight <= 1'b1;
                ret_pc   <= pc;
                ret_exc  <= fault;
            end else if (push) begin
                inflight <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Faulted fetches keep their slot but never expose memory data.
    always_ff @(posedge clk) begin
        if (!rst && push)
            q[wr_ptr] <= '{instr: (ret_exc ? 32'h0 : im_rdata), pc: ret_pc, exc: ret_exc};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: expected entries queued on accept, compared on pop.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst, pc_valid, flush, out_ready;
    logic [31:0] pc;
    logic        pc_ready;
    logic [11:0] im_addr;
    logic [31:0] im_rdata = '0;
    logic        out_valid, out_exc;
    logic [31:0] out_instr, out_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;
    exp_t sb[$];

    fetch_queue #(.DEPTH(4), .IM_ADDR_W(12), .PC_BASE(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .im_addr(im_addr), .im_rdata(im_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word k holds 0x1000_0000 + k.
    always @(posedge clk) im_rdata <= 32'h1000_0000 + {20'h0, im_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a);
        exp_t m;
        m.pc    = a;
        m.exc   = (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h7000);
        m.instr = m.exc ? 32'h0 : 32'h1000_0000 + ((a - 32'h3000) >> 2);
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_instr", out_instr, e.instr);
                    chk("out_exc", {31'h0, out_exc}, {31'h0, e.exc});
                end
            end
            if (pc_valid && pc_ready) sb.push_back(model(pc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        pc_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic acc;
        logic [31:0] fpcs [4];
        fpcs = '{32'h3002, 32'h2FFC, 32'h6FFC, 32'h7000};

        rst = 1'b1; pc_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; pc = '0;
        repeat (2) step();
        chk("rst_ready", {31'h0, pc_ready}, 0);
        chk("rst_valid", {31'h0, out_valid}, 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_exc", {31'h0, out_exc}, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, pc_ready}, 1);

        // Streaming: first out_valid two cycles after the first accept.
        out_ready = 1'b1; pc_valid = 1'b1; pc = 32'h3000;
        step();
        chk("lat_c1_valid", {31'h0, out_valid}, 0);
        pc = 32'h3004;
        step();
        chk("lat_c2_valid", {31'h0, out_valid}, 1);
        pc = 32'h3008;
        step();
        pc_valid = 1'b0;
        chk("lat_c3_valid", {31'h0, out_valid}, 1);
        step();
        chk("lat_c4_valid", {31'h0, out_valid}, 1);
        step();
        chk("lat_c5_valid", {31'h0, out_valid}, 0);
        drain();

        // Full: exactly DEPTH accepts, then one pop reopens one credit.
        out_ready = 1'b0; pc_valid = 1'b1; pc = 32'h3100; n = 0;
        repeat (8) begin
            acc = pc_ready;
            step();
            if (acc) begin n++; pc = pc + 4; end
        end
        chk("full_accepts", n, 4);
        chk("full_ready", {31'h0, pc_ready}, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ready_after_pop", {31'h0, pc_ready}, 1);
        step();
        pc_valid = 1'b0;
        drain();

        // Flush with 3 entries + in-flight.
        out_ready = 1'b0; pc_valid = 1'b1; pc = 32'h3200;
        repeat (4) begin step(); pc = pc + 4; end
        flush = 1'b1; pc_valid = 1'b0;
        #1;
        chk("flush_ready", {31'h0, pc_ready}, 0);
        step();
        flush = 1'b0;
        chk("flush_valid", {31'h0, out_valid}, 0);
        pc = 32'h3040; pc_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_flush_ready", {31'h0, pc_ready}, 1);
        step();
        pc_valid = 1'b0;
        chk("post_flush_f2_valid", {31'h0, out_valid}, 0);
        step();
        chk("post_flush_valid", {31'h0, out_valid}, 1);
        chk("post_flush_pc", out_pc, 32'h3040);
        chk("post_flush_instr", out_instr, 32'h1000_0010);
        step();
        chk("inflight_dropped", {31'h0, out_valid}, 0);
        drain();

        // Faulting and boundary addresses.
        out_ready = 1'b1; pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = fpcs[i];
            step();
        end
        drain();

        // Steady state at count=2.
        out_ready = 1'b0; pc_valid = 1'b1; pc = 32'h3300;
        step(); pc = 32'h3304;
        step(); pc = 32'h3308;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = pc + 4;
            chk("steady_count", 32'(dut.count), 2);
            chk("steady_valid", {31'h0, out_valid}, 1);
            step();
        end
        drain();

        // Reset mid-stream with 3 entries.
        out_ready = 1'b0; pc_valid = 1'b1; pc = 32'h3400;
        step(); pc = 32'h3404;
        step(); pc = 32'h3408;
        step(); pc_valid = 1'b0;
        step();
        chk("pre_rst_count", 32'(dut.count), 3);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'h0, out_valid}, 0);
        chk("mid_rst_instr", out_instr, 0);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_exc", {31'h0, out_exc}, 0);
        chk("mid_rst_ready", {31'h0, pc_ready}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'h0, pc_ready}, 1);
        step();
        chk("post_rst_valid", {31'h0, out_valid}, 0);

        chk("sb_left", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch stage sitting directly downstream of the PC register: it accepts the current PC, issues a read to the synchronous instruction memory, and buffers returned instructions with their PCs in a small FIFO feeding decode. Back-pressure from decode propagates to the PC stage through `pc_ready`, so the PC holds while the queue is full. A `flush` input discards all buffered and in-flight fetches on a branch/jump redirect.

## Interface
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `IM_ADDR_W`, 12, instruction-memory word-address width
- `PC_BASE`, 32'h0000_3000, PC of instruction-memory word 0
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `pc`  in  32  fetch address from PC stage
- `pc_valid`  in  1  `pc` is a fetch request
- `pc_ready`  out  1  request accepted this cycle (PC may advance)
- `flush`  in  1  redirect: discard queue and in-flight fetch
- `im_addr`  out  IM_ADDR_W  word address to instruction memory
- `im_rdata`  in  32  instruction memory data, valid one cycle after `im_addr`
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  decode consumes head
- `out_instr`  out  32  head instruction
- `out_pc`  out  32  head PC
- `out_exc`  out  1  head fetch faulted (AdEL)

## Operation
- Accept = `pc_valid && pc_ready`. `pc_ready = !rst && !flush && (count + inflight < DEPTH)`; combinational, no dependence on `pc_valid`.
- `im_addr = (pc - PC_BASE)[IM_ADDR_W+1:2]`, driven combinationally every cycle.
- On accept: set `inflight`, latch `pc` and fault flag into a 1-entry return register.
- Fault: `pc[1:0] != 0` or `pc < PC_BASE` or `pc >= PC_BASE + 4·2^IM_ADDR_W`. Faulted entry stores `out_instr = 0`, `out_exc = 1`; still occupies a slot and still counts as in-flight.
- Return cycle (`inflight` set, no flush): write {`im_rdata` or 0, latched pc, fault} to tail; clear `inflight` unless a new accept occurs the same cycle.
- Pop = `out_valid && out_ready`; advances head. Push and pop in the same cycle leave `count` unchanged.
- `count` range 0..DEPTH; pointers wrap modulo DEPTH. Never overflows: credit includes the in-flight slot.
- Empty: `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `out_exc = 0`.
- `flush`: next edge `count = 0`, pointers = 0, `inflight = 0`; the return arriving in the cycle after flush is dropped; pop in the flush cycle ignored; no accept in the flush cycle.
- `rst` overrides `flush`.

## Timing
- Reset (edge with `rst=1`): `count=0`, pointers 0, `inflight=0`; `out_valid=0`, `out_instr=0`, `out_pc=0`, `out_exc=0`; `pc_ready=0` while `rst` high, 1 in the first cycle after.
- Latency: accept in cycle N → `im_rdata` valid in N+1 → entry written at end of N+1 → `out_valid=1` in N+2. No bypass.
- Throughput: 1 fetch/cycle with `out_ready` held high.
- Full: `pc_ready` drops in the cycle where `count + inflight == DEPTH`; rises in the cycle after a pop frees a slot.
- Flush in cycle F: `pc_ready=0` in F; `out_valid=0` in F+1; a new accept is allowed in F+1.

## Test plan
- Reset, then `pc_valid=1` with `pc` stepping 0x3000, 0x3004, 0x3008 and `out_ready=1`, memory word k = 0x1000_0000+k → `out_valid` first in cycle 2; `out_pc`/`out_instr` = 0x3000/0x1000_0000, 0x3004/0x1000_0001, 0x3008/0x1000_0002 on consecutive cycles.
- `out_ready=0`, continuous requests → exactly 4 accepts, then `pc_ready=0` held; raise `out_ready` for one cycle → one pop, `pc_ready=1` the next cycle, order preserved.
- Fill to 3 entries plus in-flight, assert `flush` for one cycle → `out_valid=0` next cycle; the in-flight word never appears; the next accepted `pc=0x3040` emerges first with the correct instruction.
- `pc=0x3002` then `pc=0x2FFC` → two entries with `out_exc=1`, `out_instr=0`, `out_pc` = 0x3002, 0x2FFC.
- Steady-state push and pop with `count=2` → `count` stays 2 and there are no gaps in `out_valid`.
- Assert `rst` mid-stream with 3 entries → next cycle all outputs 0, `pc_ready=0`; deassert → `pc_ready=1` with an empty queue.
